// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two valid/ready requesters.
// Round-robin grant in IDLE, operands held on the ALU for EXEC_CYCLES,
// registered result returned to the winner over a response handshake.
module alu_share_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Req0Valid,
    output logic                  Req0Ready,
    input  logic [3:0]            Req0Ctrl,
    input  logic [DATA_WIDTH-1:0] Req0A,
    input  logic [DATA_WIDTH-1:0] Req0B,
    input  logic                  Req1Valid,
    output logic                  Req1Ready,
    input  logic [3:0]            Req1Ctrl,
    input  logic [DATA_WIDTH-1:0] Req1A,
    input  logic [DATA_WIDTH-1:0] Req1B,
    output logic                  Rsp0Valid,
    input  logic                  Rsp0Ready,
    output logic                  Rsp1Valid,
    input  logic                  Rsp1Ready,
    output logic [DATA_WIDTH-1:0] RspData,
    output logic                  RspZero,
    output logic                  RspErr,
    output logic [DATA_WIDTH-1:0] AluA,
    output logic [DATA_WIDTH-1:0] AluB,
    output logic [3:0]            AluCtrl,
    input  logic [DATA_WIDTH-1:0] AluW,
    input  logic                  AluZero,
    output logic                  Busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD  = 4'(EXEC_CYCLES - 1);
    localparam logic [3:0] CTRL_PASS = 4'b0111;

    logic [1:0]            state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  id_q, id_d;
    logic [3:0]            ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_zero_q, rsp_zero_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  winner;
    logic                  accept;
    logic                  rsp_ready_sel;
    logic [3:0]            win_ctrl;

    // Grant selection: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        winner = ptr_q;
        if (Req0Valid && !Req1Valid) begin
            winner = 1'b0;
        end else if (Req1Valid && !Req0Valid) begin
            winner = 1'b1;
        end
        Req0Ready     = (state_q == S_IDLE) && !winner;
        Req1Ready     = (state_q == S_IDLE) && winner;
        accept        = (Req0Valid && Req0Ready) || (Req1Valid && Req1Ready);
        win_ctrl      = winner ? Req1Ctrl : Req0Ctrl;
        rsp_ready_sel = id_q ? Rsp1Ready : Rsp0Ready;
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        ctrl_d     = ctrl_q;
        a_d        = a_q;
        b_d        = b_q;
        err_d      = err_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    id_d    = winner;
                    ctrl_d  = win_ctrl;
                    a_d     = winner ? Req1A : Req0A;
                    b_d     = winner ? Req1B : Req0B;
                    err_d   = !(win_ctrl inside {4'b0000, 4'b0001, 4'b0010,
                                                 4'b0110, 4'b0111});
                    cnt_d   = CNT_LOAD;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d = AluW;
                    rsp_zero_d = AluZero;
                    rsp_err_d  = err_q;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_sel) begin
                    ptr_d   = !id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset drops any in-flight op.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            id_q       <= 1'b0;
            ctrl_q     <= CTRL_PASS;
            a_q        <= '0;
            b_q        <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            ctrl_q     <= ctrl_d;
            a_q        <= a_d;
            b_q        <= b_d;
            err_q      <= err_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign AluA      = a_q;
    assign AluB      = b_q;
    assign AluCtrl   = ctrl_q;
    assign RspData   = rsp_data_q;
    assign RspZero   = rsp_zero_q;
    assign RspErr    = rsp_err_q;
    assign Rsp0Valid = (state_q == S_RESP) && !id_q;
    assign Rsp1Valid = (state_q == S_RESP) && id_q;
    assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: table-driven single operations plus
// hand-written arbitration, spacing, long-EXEC and reset sequences.
module tb_alu_share_arbiter;

    typedef struct {
        logic        id;
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_data;
        logic        exp_zero;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0v = 1'b0, r1v = 1'b0, r0v4 = 1'b0, zero_in = 1'b0;
    logic [3:0]  r0c = '0, r1c = '0;
    logic [63:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
    logic        p0r = 1'b0, p1r = 1'b0;

    logic        r0rdy, r1rdy, s0v, s1v, rzero, rerr, aluz, busy;
    logic [63:0] rdata, alua, alub, aluw;
    logic [3:0]  aluc;
    logic        r0rdy4, r1rdy4, s0v4, s1v4, rzero4, rerr4, aluz4, busy4;
    logic [63:0] rdata4, alua4, alub4, aluw4;
    logic [3:0]  aluc4;

    int total = 0;
    int bad   = 0;
    vec_t vecs[7];

    always #5 clk = ~clk;

    // Reference ALU: illegal codes return 0.
    function automatic logic [63:0] alu_f(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            default: return 64'd0;
        endcase
    endfunction

    assign aluw  = alu_f(aluc, alua, alub);
    assign aluz  = (aluw == 64'd0);
    assign aluw4 = alu_f(aluc4, alua4, alub4);
    assign aluz4 = (aluw4 == 64'd0);

    alu_share_arbiter #(.DATA_WIDTH(64), .EXEC_CYCLES(1)) dut (
        .CLK(clk), .Reset(rst),
        .Req0Valid(r0v), .Req0Ready(r0rdy), .Req0Ctrl(r0c), .Req0A(r0a), .Req0B(r0b),
        .Req1Valid(r1v), .Req1Ready(r1rdy), .Req1Ctrl(r1c), .Req1A(r1a), .Req1B(r1b),
        .Rsp0Valid(s0v), .Rsp0Ready(p0r), .Rsp1Valid(s1v), .Rsp1Ready(p1r),
        .RspData(rdata), .RspZero(rzero), .RspErr(rerr),
        .AluA(alua), .AluB(alub), .AluCtrl(aluc), .AluW(aluw), .AluZero(aluz),
        .Busy(busy)
    );

    alu_share_arbiter #(.DATA_WIDTH(64), .EXEC_CYCLES(4)) dut4 (
        .CLK(clk), .Reset(rst),
        .Req0Valid(r0v4), .Req0Ready(r0rdy4), .Req0Ctrl(r0c), .Req0A(r0a), .Req0B(r0b),
        .Req1Valid(zero_in), .Req1Ready(r1rdy4), .Req1Ctrl(r1c), .Req1A(r1a), .Req1B(r1b),
        .Rsp0Valid(s0v4), .Rsp0Ready(p0r), .Rsp1Valid(s1v4), .Rsp1Ready(p1r),
        .RspData(rdata4), .RspZero(rzero4), .RspErr(rerr4),
        .AluA(alua4), .AluB(alub4), .AluCtrl(aluc4), .AluW(aluw4), .AluZero(aluz4),
        .Busy(busy4)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // One operation on the EXEC_CYCLES=1 instance, response taken at once.
    task automatic run_op(input vec_t v);
        int lat;
        @(negedge clk);
        if (!v.id) begin
            r0v = 1'b1; r0c = v.ctrl; r0a = v.a; r0b = v.b;
        end else begin
            r1v = 1'b1; r1c = v.ctrl; r1a = v.a; r1b = v.b;
        end
        #1;
        chk("win_ready", v.id ? r1rdy : r0rdy, 1);
        chk("lose_ready", v.id ? r0rdy : r1rdy, 0);
        @(negedge clk);
        r0v = 1'b0; r1v = 1'b0;
        chk("busy_exec", busy, 1);
        lat = 1;
        while (!(v.id ? s1v : s0v) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 2);
        chk("rsp_data", rdata, v.exp_data);
        chk("rsp_zero", rzero, v.exp_zero);
        chk("rsp_err", rerr, v.exp_err);
        chk("other_rsp_valid", v.id ? s0v : s1v, 0);
        if (!v.id) p0r = 1'b1; else p1r = 1'b1;
        @(negedge clk);
        p0r = 1'b0; p1r = 1'b0;
        chk("idle_after_rsp", busy, 0);
    endtask

    initial begin
        int lat, n, viol;
        int acc[3];

        vecs[0] = '{1'b0, 4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'b1111, 64'd3, 64'd4, 64'd0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 4'b0111, 64'd9, 64'd0, 64'd0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 4'b0001, 64'hA, 64'h5, 64'hF, 1'b0, 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp0v", s0v, 0);
        chk("rst_rsp1v", s1v, 0);
        chk("rst_aluctrl", aluc, 4'b0111);
        chk("rst_alua", alua, 0);
        chk("rst_alub", alub, 0);
        chk("rst_rspdata", rdata, 0);

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Both valid: pointer starts at 0 after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r0v = 1'b1; r0c = 4'b0110; r0a = 64'd9; r0b = 64'd9;
        r1v = 1'b1; r1c = 4'b0001; r1a = 64'hF0; r1b = 64'h0F;
        #1;
        chk("tie_r0_ready", r0rdy, 1);
        chk("tie_r1_ready", r1rdy, 0);
        @(negedge clk);
        r0v = 1'b0;
        lat = 1;
        while (!s0v && lat < 20) begin @(negedge clk); lat++; end
        chk("tie_lat0", lat, 2);
        chk("tie_data0", rdata, 0);
        chk("tie_zero0", rzero, 1);
        chk("resp_r1_ready", r1rdy, 0);
        p0r = 1'b1;
        @(negedge clk);
        p0r = 1'b0;
        r0v = 1'b1;
        #1;
        chk("ptr1_r1_ready", r1rdy, 1);
        chk("ptr1_r0_ready", r0rdy, 0);
        @(negedge clk);
        r0v = 1'b0; r1v = 1'b0;
        lat = 1;
        while (!s1v && lat < 20) begin @(negedge clk); lat++; end
        chk("tie_lat1", lat, 2);
        chk("tie_data1", rdata, 64'hFF);
        chk("tie_zero1", rzero, 0);
        p1r = 1'b1;
        @(negedge clk);
        p1r = 1'b0;
        r0v = 1'b1; r1v = 1'b1;
        #1;
        chk("ptr0_r0_ready", r0rdy, 1);
        chk("ptr0_r1_ready", r1rdy, 0);
        r0v = 1'b0; r1v = 1'b0;

        // Req1 streaming with Req0 idle: accepts spaced exactly 3 cycles
        @(negedge clk);
        r1v = 1'b1; r1c = 4'b0010; r1a = 64'd1; r1b = 64'd2; p1r = 1'b1;
        n = 0; viol = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (r1v && r1rdy) begin
                if (n < 3) acc[n] = c;
                n++;
            end
            if (r1rdy && busy) viol++;
            if (s1v && rdata != 64'd3) viol++;
            @(negedge clk);
            if (c + 1 == 7) r1v = 1'b0;
        end
        p1r = 1'b0;
        chk("stream_count", n, 3);
        chk("stream_gap01", acc[1] - acc[0], 3);
        chk("stream_gap12", acc[2] - acc[1], 3);
        chk("stream_viol", viol, 0);

        // Reset during EXEC discards the operation
        @(negedge clk);
        r0v = 1'b1; r0c = 4'b0010; r0a = 64'd5; r0b = 64'd7;
        @(negedge clk);
        r0v = 1'b0;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp0v", s0v, 0);
        chk("midrst_rspdata", rdata, 0);
        chk("midrst_aluctrl", aluc, 4'b0111);
        chk("midrst_alua", alua, 0);
        chk("midrst_alub", alub, 0);
        viol = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (s0v || s1v || busy) viol++;
        end
        chk("midrst_no_rsp", viol, 0);

        // EXEC_CYCLES=4 instance, PassB, response held off for 5 cycles
        @(negedge clk);
        r0v4 = 1'b1; r0c = 4'b0111; r0a = 64'h1234; r0b = 64'hDEAD; p0r = 1'b0;
        #1;
        chk("e4_ready", r0rdy4, 1);
        @(negedge clk);
        r0v4 = 1'b0; r0a = 64'h5555; r0b = 64'h6666; r0c = 4'b0000;
        lat = 1; viol = 0;
        while (!s0v4 && lat < 20) begin
            if (alua4 != 64'h1234 || alub4 != 64'hDEAD || aluc4 != 4'b0111) viol++;
            @(negedge clk);
            lat++;
        end
        chk("e4_latency", lat, 5);
        chk("e4_alu_stable", viol, 0);
        viol = 0;
        for (int c = 0; c < 5; c++) begin
            if (!s0v4 || rdata4 != 64'hDEAD || rzero4 || rerr4) viol++;
            @(negedge clk);
        end
        chk("e4_hold", viol, 0);
        chk("e4_data", rdata4, 64'hDEAD);
        p0r = 1'b1;
        @(negedge clk);
        p0r = 1'b0;
        chk("e4_idle", busy4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
